rotate_norm_seq: RTL and testbench



---
 rtl/rotate_norm_seq_if.sv | 13 +
 rtl/rotate_norm_seq.sv | 51 +++++
 tb/tb_rotate_norm_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rotate_norm_seq_if.sv
// rotate_norm_seq_if: word-in (in_valid/in_ready/in_data) and result-out (out_valid/out_ready/m_o/s_o/zero_o) handshakes
interface rotate_norm_seq_if #(parameter int WIDTH = 16, parameter int SW = 4);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] m_o;
  logic [SW-1:0] s_o;
  logic zero_o;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, m_o, s_o, zero_o);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, m_o, s_o, zero_o);
endinterface

// File: rtl/rotate_norm_seq.sv
// rotate_norm_seq: bit-serial leading-one scan giving the left-rotate amount (ports clk, rst_n sync active-low, io slave: in_valid/in_ready/in_data in, out_valid/out_ready/m_o/s_o/zero_o out)
module rotate_norm_seq #(
  parameter int WIDTH = 16,
  parameter int SW = 4
) (
  input logic clk,
  input logic rst_n,
  rotate_norm_seq_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
  logic [1:0] state, nxt;
  logic [WIDTH-1:0] work;
  logic [SW-1:0] cnt;
  logic hit;
  assign hit = (work == '0) || work[WIDTH-1];
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (io.in_valid ? SCAN : IDLE) :
          state == SCAN ? (hit ? DONE : SCAN) :
          (io.out_ready ? IDLE : DONE);
  end
  always_comb begin
    io.in_ready = rst_n && state == IDLE;
    io.out_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.m_o <= '0;
      io.s_o <= '0;
      io.zero_o <= 1'b0;
      work <= '0;
      cnt <= '0;
    end else if (state == IDLE && io.in_valid) begin
      io.m_o <= io.in_data;
      work <= io.in_data;
      cnt <= '0;
    end else if (state == SCAN) begin
      if (work == '0) begin
        io.zero_o <= 1'b1;
        io.s_o <= '0;
      end else if (work[WIDTH-1]) begin
        io.zero_o <= 1'b0;
        io.s_o <= cnt;
      end else begin
        work <= work << 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rotate_norm_seq.sv
// tb_rotate_norm_seq: directed and random scoreboard bench for rotate_norm_seq
module tb_rotate_norm_seq;
  typedef struct {
    logic [15:0] m;
    logic [3:0] s;
    logic z;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc = 0;
  int mode = 0;
  bit seen = 0;
  bit chk_idle = 0;
  exp_t q[$];
  rotate_norm_seq_if #(.WIDTH(16), .SW(4)) io ();
  rotate_norm_seq #(.WIDTH(16), .SW(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int lz(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) if (w[i]) return 15 - i;
    return 0;
  endfunction
  function automatic logic [15:0] rotl(input logic [15:0] m, input int s);
    logic [15:0] r;
    r = (m << s) | (m >> (16 - s));
    return r;
  endfunction
  initial begin
    io.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("idle_in_ready", int'(io.in_ready), 1);
        chk("idle_out_valid", int'(io.out_valid), 0);
        chk_idle = 0;
      end
      if (io.in_valid && io.in_ready) acc = cyc + 1;
      if (io.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - acc, q[0].lat);
          end
          chk("m_o", int'(io.m_o), int'(q[0].m));
          chk("s_o", int'(io.s_o), int'(q[0].s));
          chk("zero_o", int'(io.zero_o), int'(q[0].z));
          chk("busy_in_ready", int'(io.in_ready), 0);
          if (!q[0].z) chk("rotl_msb", int'(rotl(io.m_o, int'(io.s_o)) >> 15), 1);
          if (io.out_ready) begin
            void'(q.pop_front());
            seen = 0;
            chk_idle = 1;
          end
        end
      end
    end
  end
  task automatic send(input logic [15:0] d, input int s, input bit z);
    exp_t e;
    int t;
    @(posedge clk);
    #1;
    io.in_valid = 1;
    io.in_data = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (io.in_ready) break;
      if (++t > 200) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    e.m = d;
    e.s = 4'(s);
    e.z = z;
    e.lat = z ? 1 : s + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    io.in_valid = 0;
    io.in_data = 16'($urandom);
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!io.out_valid) begin
      @(negedge clk);
      if (++t > 100) begin
        chk("valid_timeout", 1, 0);
        break;
      end
    end
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", q.size(), 0);
  endtask
  initial begin
    logic [15:0] w;
    io.in_valid = 0;
    io.in_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(io.in_ready), 0);
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_m", int'(io.m_o), 0);
    chk("rst_s", int'(io.s_o), 0);
    chk("rst_zero", int'(io.zero_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready_after_rst", int'(io.in_ready), 1);
    send(16'h8001, 0, 0);
    drain();
    send(16'h0001, 15, 0);
    drain();
    send(16'h0000, 0, 1);
    drain();
    mode = 1;
    send(16'h0340, 6, 0);
    wait_valid();
    @(posedge clk);
    #1;
    io.in_valid = 1;
    io.in_data = 16'hFFFF;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", int'(io.in_ready), 0);
    end
    mode = 0;
    send(16'hFFFF, 0, 0);
    drain();
    send(16'h0010, 11, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst_low_in_ready", int'(io.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", int'(io.out_valid), 0);
    chk("mid_rst_m", int'(io.m_o), 0);
    chk("mid_rst_s", int'(io.s_o), 0);
    chk("mid_rst_in_ready", int'(io.in_ready), 1);
    send(16'h0010, 11, 0);
    drain();
    mode = 2;
    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom_range(1, 65535)) >> $urandom_range(0, 15);
      if (w == 0) w = 16'h0001;
      send(w, lz(w), 0);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
